// File: rtl/fetch_reg1_pkg.sv
// Shared definitions for the fetch stage: NOP word, FSM encodings and instruction field positions.
package fetch_reg1_pkg;

   localparam logic [31:0] NOP_INST = 32'h4000_0009;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   localparam int OPC_MSB   = 30;
   localparam int OPC_LSB   = 25;
   localparam int SUBB_BIT  = 14;
   localparam int SUBJ_BIT  = 24;
   localparam int IMM14_MSB = 13;
   localparam int IMM24_MSB = 23;

endpackage

// File: rtl/fetch_reg1_hold_buf.sv
// One-entry {word, pc, valid} parking buffer for a word acked while the pipeline is frozen.
module fetch_reg1_hold_buf #(
   parameter int PC_W   = 10,
   parameter int INST_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              drop,
   input  logic              unload,
   input  logic [INST_W-1:0] load_word,
   input  logic [PC_W-1:0]   load_pc,
   output logic [INST_W-1:0] word,
   output logic [PC_W-1:0]   pc,
   output logic              valid
);
   import fetch_reg1_pkg::*;

   logic              valid_q, valid_d;
   logic [INST_W-1:0] word_q, word_d;
   logic [PC_W-1:0]   pc_q, pc_d;

   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      pc_d    = pc_q;
      if (drop || unload) begin
         valid_d = 1'b0;
      end
      if (load) begin
         valid_d = 1'b1;
         word_d  = load_word;
         pc_d    = load_pc;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // payload is only meaningful while valid_q is set, so it carries no reset
   always_ff @(posedge clock) begin
      word_q <= word_d;
      pc_q   <= pc_d;
   end

   assign word  = word_q;
   assign pc    = pc_q;
   assign valid = valid_q;

endmodule

// File: rtl/fetch_reg1.sv
// Instruction fetch over a req/ack port feeding the IF/ID register (REG1), with stall/flush control.
// Defining FETCH_PERF_EN adds saturating perf_fetch / perf_stall / perf_flush counters.
module fetch_reg1 #(
   parameter int                PC_W     = 10,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = fetch_reg1_pkg::NOP_INST
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [PC_W-1:0]   current_pc,
   output logic              enable_pc,
   input  logic              do_hazard,
   input  logic              do_flush_REG1,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [INST_W-1:0] ir,
   output logic [PC_W-1:0]   ir_pc,
   output logic              ir_valid,
   output logic [5:0]        opcode,
   output logic              sub_op_b,
   output logic              sub_op_j,
   output logic [13:0]       imm_14bit,
   output logic [23:0]       imm_24bit
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]       perf_fetch,
   output logic [15:0]       perf_stall,
   output logic [15:0]       perf_flush
`endif
);
   import fetch_reg1_pkg::*;

   fetch_state_e      state_q, state_d;
   logic              fresh_q, fresh_d;
   logic              discard_q, discard_d;
   logic [PC_W-1:0]   addr_q, addr_d;
   logic [PC_W-1:0]   req_addr;
   logic [INST_W-1:0] ir_q, ir_d;
   logic [PC_W-1:0]   ir_pc_q, ir_pc_d;
   logic              ir_valid_q, ir_valid_d;
   logic              en_pc;
   logic              flush_go;
   logic              hb_load, hb_drop, hb_unload, hb_valid;
   logic [INST_W-1:0] hb_word;
   logic [PC_W-1:0]   hb_pc;

   // The PC settles only after the enable_pc edge, so a new request samples
   // current_pc live in its first cycle and holds the latched copy afterwards.
   assign req_addr = (state_q == REQ && fresh_q) ? current_pc : addr_q;
   assign flush_go = do_flush_REG1 && !do_hazard;

   always_comb begin
      state_d    = state_q;
      fresh_d    = fresh_q;
      discard_d  = discard_q;
      addr_d     = addr_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      en_pc      = 1'b0;
      hb_load    = 1'b0;
      hb_drop    = 1'b0;
      hb_unload  = 1'b0;

      if (state_q == REQ && fresh_q) begin
         addr_d  = current_pc;
         fresh_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (!do_hazard) begin
               state_d = REQ;
               fresh_d = 1'b1;
            end
         end
         REQ: begin
            if (imem_ack) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = IDLE;
               end else if (do_hazard) begin
                  hb_load = 1'b1;
                  state_d = HOLD;
               end else if (!do_flush_REG1) begin
                  ir_d       = imem_rdata;
                  ir_pc_d    = req_addr;
                  ir_valid_d = 1'b1;
                  en_pc      = 1'b1;
                  state_d    = REQ;
                  fresh_d    = 1'b1;
               end else begin
                  state_d = REQ;
                  fresh_d = 1'b1;
               end
            end else if (flush_go) begin
               discard_d = 1'b1;
            end
         end
         HOLD: begin
            if (!do_hazard) begin
               if (!do_flush_REG1 && hb_valid) begin
                  ir_d       = hb_word;
                  ir_pc_d    = hb_pc;
                  ir_valid_d = 1'b1;
                  hb_unload  = 1'b1;
                  en_pc      = 1'b1;
               end else begin
                  hb_drop = 1'b1;
               end
               state_d = REQ;
               fresh_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // a squash also releases the PC so it can take the redirect
      if (flush_go) begin
         ir_d       = NOP_INST;
         ir_valid_d = 1'b0;
         en_pc      = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         fresh_q    <= 1'b0;
         discard_q  <= 1'b0;
         ir_q       <= NOP_INST;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fresh_q    <= fresh_d;
         discard_q  <= discard_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   always_ff @(posedge clock) begin
      addr_q <= addr_d;
   end

   fetch_reg1_hold_buf #(
      .PC_W   (PC_W),
      .INST_W (INST_W)
   ) u_hold_buf (
      .clock     (clock),
      .reset     (reset),
      .load      (hb_load),
      .drop      (hb_drop),
      .unload    (hb_unload),
      .load_word (imem_rdata),
      .load_pc   (req_addr),
      .word      (hb_word),
      .pc        (hb_pc),
      .valid     (hb_valid)
   );

   assign enable_pc = en_pc && !reset;
   assign imem_req  = (state_q == REQ);
   assign imem_addr = req_addr;
   assign ir        = ir_q;
   assign ir_pc     = ir_pc_q;
   assign ir_valid  = ir_valid_q;
   assign opcode    = ir_q[OPC_MSB:OPC_LSB];
   assign sub_op_b  = ir_q[SUBB_BIT];
   assign sub_op_j  = ir_q[SUBJ_BIT];
   assign imm_14bit = ir_q[IMM14_MSB:0];
   assign imm_24bit = ir_q[IMM24_MSB:0];

`ifdef FETCH_PERF_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [15:0] perf_fetch_q, perf_fetch_d;
   logic [15:0] perf_stall_q, perf_stall_d;
   logic [15:0] perf_flush_q, perf_flush_d;

   // an enable_pc pulse that is not a flush redirect means a word entered REG1
   always_comb begin
      perf_fetch_d = (en_pc && !flush_go) ? sat_inc16(perf_fetch_q) : perf_fetch_q;
      perf_stall_d = do_hazard ? sat_inc16(perf_stall_q) : perf_stall_q;
      perf_flush_d = flush_go ? sat_inc16(perf_flush_q) : perf_flush_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_fetch_q <= '0;
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_fetch = perf_fetch_q;
   assign perf_stall = perf_stall_q;
   assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_reg1.sv
// Directed bench for fetch_reg1: reset, fetch stream, decode, hazard, flush, flush+ack and reset-mid-fetch.
module tb_fetch_reg1;
   localparam int PC_W   = 10;
   localparam int INST_W = 32;
   localparam logic [31:0] NOP = 32'h4000_0009;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [PC_W-1:0]   current_pc = '0;
   logic              enable_pc;
   logic              do_hazard = 1'b0;
   logic              do_flush_REG1 = 1'b0;
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_ack = 1'b0;
   logic [INST_W-1:0] imem_rdata = '0;
   logic [INST_W-1:0] ir;
   logic [PC_W-1:0]   ir_pc;
   logic              ir_valid;
   logic [5:0]        opcode;
   logic              sub_op_b;
   logic              sub_op_j;
   logic [13:0]       imm_14bit;
   logic [23:0]       imm_24bit;
`ifdef FETCH_PERF_EN
   logic [15:0]       perf_fetch, perf_stall, perf_flush;
`endif

   int errors = 0;
   int checks = 0;
   logic [31:0]     exp_ir = NOP;
   logic [PC_W-1:0] exp_pc = '0;
   logic            exp_valid = 1'b0;

   fetch_reg1 dut (
      .clock         (clock),
      .reset         (reset),
      .current_pc    (current_pc),
      .enable_pc     (enable_pc),
      .do_hazard     (do_hazard),
      .do_flush_REG1 (do_flush_REG1),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .ir            (ir),
      .ir_pc         (ir_pc),
      .ir_valid      (ir_valid),
      .opcode        (opcode),
      .sub_op_b      (sub_op_b),
      .sub_op_j      (sub_op_j),
      .imm_14bit     (imm_14bit),
      .imm_24bit     (imm_24bit)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch    (perf_fetch),
      .perf_stall    (perf_stall),
      .perf_flush    (perf_flush)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   task automatic check_reg1(input string tag);
      check({tag, ".ir"}, ir, exp_ir);
      check({tag, ".ir_pc"}, 32'(ir_pc), 32'(exp_pc));
      check({tag, ".ir_valid"}, 32'(ir_valid), 32'(exp_valid));
   endtask

   // first REQ cycle at pc, then a one-cycle ack carrying word
   task automatic fetch_ack(input logic [PC_W-1:0] pc, input logic [31:0] word);
      nxt();
      current_pc = pc; imem_ack = 1'b0; do_hazard = 1'b0; do_flush_REG1 = 1'b0;
      smp();
      check_reg1("fetch_pre");
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_addr", 32'(imem_addr), 32'(pc));
      check("fetch_en_wait", 32'(enable_pc), 32'd0);
      nxt();
      imem_ack = 1'b1; imem_rdata = word;
      smp();
      check("fetch_en_ack", 32'(enable_pc), 32'd1);
      exp_ir = word; exp_pc = pc; exp_valid = 1'b1;
   endtask

   initial begin
      // 1. reset state and stepping fetch stream
      smp();
      check_reg1("reset");
      check("reset_req", 32'(imem_req), 32'd0);
      check("reset_en", 32'(enable_pc), 32'd0);
      check("reset_opcode", 32'(opcode), 32'h20);
      nxt();
      reset = 1'b0; current_pc = '0;
      smp();
      check("idle_req", 32'(imem_req), 32'd0);
      check("idle_en", 32'(enable_pc), 32'd0);
      fetch_ack(10'd0, 32'h1234_5678);
      fetch_ack(10'd4, 32'h4C00_0003);

      // 2. BEQ decode, then 3. hazard across ack at addr 8
      nxt();
      current_pc = 10'd8; imem_ack = 1'b0;
      smp();
      check_reg1("beq");
      check("beq_opcode", 32'(opcode), 32'h26);
      check("beq_sub_b", 32'(sub_op_b), 32'd0);
      check("beq_sub_j", 32'(sub_op_j), 32'd0);
      check("beq_imm14", 32'(imm_14bit), 32'h0003);
      check("beq_imm24", 32'(imm_24bit), 32'h00_0003);
      check("addr8", 32'(imem_addr), 32'd8);
      nxt();
      do_hazard = 1'b1;
      smp();
      check("hz1_en", 32'(enable_pc), 32'd0);
      check("hz1_req", 32'(imem_req), 32'd1);
      nxt();
      imem_ack = 1'b1; imem_rdata = 32'hA5A5_4321;
      smp();
      check("hz2_en", 32'(enable_pc), 32'd0);
      nxt();
      imem_ack = 1'b0;
      smp();
      check("hz3_en", 32'(enable_pc), 32'd0);
      check_reg1("hz3");
      nxt();
      do_hazard = 1'b0;
      smp();
      check("hz_drop_en", 32'(enable_pc), 32'd1);
      check_reg1("hz_drop");
      exp_ir = 32'hA5A5_4321; exp_pc = 10'd8; exp_valid = 1'b1;
      nxt();
      current_pc = 10'd12;
      smp();
      check_reg1("hold_land");
      check("hold_opcode", 32'(opcode), 32'h12);
      check("hold_sub_b", 32'(sub_op_b), 32'd1);
      check("hold_sub_j", 32'(sub_op_j), 32'd1);
      check("hold_imm14", 32'(imm_14bit), 32'h0321);
      check("hold_imm24", 32'(imm_24bit), 32'hA5_4321);
      check("addr12", 32'(imem_addr), 32'd12);

      // 4. flush while REQ pending, ack two cycles later
      nxt();
      do_flush_REG1 = 1'b1;
      smp();
      check("fl_en", 32'(enable_pc), 32'd1);
      exp_ir = NOP; exp_valid = 1'b0;
      nxt();
      do_flush_REG1 = 1'b0; current_pc = 10'd40;
      smp();
      check("fl_c2_en", 32'(enable_pc), 32'd0);
      check("fl_c2_addr", 32'(imem_addr), 32'd12);
      check_reg1("fl_c2");
      nxt();
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      smp();
      check("fl_ack_en", 32'(enable_pc), 32'd0);
      nxt();
      imem_ack = 1'b0;
      smp();
      check("fl_idle_req", 32'(imem_req), 32'd0);
      check("fl_idle_en", 32'(enable_pc), 32'd0);
      check_reg1("fl_drop");
      fetch_ack(10'd40, 32'h0000_1111);

      // 5. flush and ack in the same cycle
      nxt();
      current_pc = 10'd44; imem_ack = 1'b0;
      smp();
      check_reg1("fa_pre");
      check("fa_addr", 32'(imem_addr), 32'd44);
      nxt();
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0044; do_flush_REG1 = 1'b1;
      smp();
      check("fa_en", 32'(enable_pc), 32'd1);
      exp_ir = NOP; exp_valid = 1'b0;
      fetch_ack(10'h3FC, 32'h7777_0001);

      // 6. reset mid-fetch, stale ack right after release
      nxt();
      current_pc = 10'h200; imem_ack = 1'b0; reset = 1'b1;
      smp();
      exp_ir = NOP; exp_pc = '0; exp_valid = 1'b0;
      check_reg1("rst_mid");
      check("rst_mid_req", 32'(imem_req), 32'd0);
      check("rst_mid_en", 32'(enable_pc), 32'd0);
      nxt();
      reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      smp();
      check("stale_req", 32'(imem_req), 32'd0);
      check("stale_en", 32'(enable_pc), 32'd0);
      fetch_ack(10'h200, 32'h0BAD_CAFE);
      nxt();
      imem_ack = 1'b0;
      smp();
      check_reg1("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
